// File: rtl/if_prefetch_unit_if.sv
// Instruction memory request/response channel between the prefetch unit (master)
// and instruction memory (slave).
interface if_prefetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction fetch front end: in-order word fetches into a DEPTH-entry circular
// queue of {pc, instr}, with stall, flush/redirect and halt.
module if_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    if_prefetch_unit_if.master  imem,
    input  logic                stall,
    input  logic                flush,
    input  logic [15:0]         redirect_pc,
    input  logic                halt,
    output logic                if_valid,
    output logic [15:0]         if_pc,
    output logic [15:0]         if_instr
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [15:0]      slot_pc    [DEPTH];
    logic [15:0]      slot_instr [DEPTH];
    logic [DEPTH-1:0] slot_filled;

    ptr_t        head;
    ptr_t        tail;
    ptr_t        fill;
    cnt_t        alloc_cnt;
    cnt_t        drop_cnt;
    cnt_t        pend_cnt;
    logic [15:0] fetch_pc;

    logic req_ok;
    logic accept;
    logic head_valid;
    logic pop;
    logic rsp_fill;
    logic rsp_drop;

    always_comb begin
        req_ok     = !rst && !flush && !halt && ((alloc_cnt + drop_cnt) < DEPTH_C);
        accept     = req_ok && imem.imem_req_ready;
        head_valid = (alloc_cnt != '0) && slot_filled[head];
        pop        = head_valid && !stall && !flush;
        rsp_fill   = imem.imem_rsp_valid && (drop_cnt == '0);
        rsp_drop   = imem.imem_rsp_valid && (drop_cnt != '0);
    end

    assign imem.imem_req_valid = req_ok;
    assign imem.imem_req_addr  = fetch_pc;

    assign if_valid = head_valid;
    assign if_pc    = head_valid ? slot_pc[head]    : '0;
    assign if_instr = head_valid ? slot_instr[head] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            slot_filled <= '0;
            alloc_cnt   <= '0;
            drop_cnt    <= '0;
            pend_cnt    <= '0;
        end else if (flush) begin
            // Every still-outstanding live request becomes a drop; a response in this
            // cycle retires either an old drop or one of those requests, so it is -1 both ways.
            drop_cnt    <= drop_cnt + pend_cnt - cnt_t'(imem.imem_rsp_valid);
            fetch_pc    <= redirect_pc;
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            slot_filled <= '0;
            alloc_cnt   <= '0;
            pend_cnt    <= '0;
        end else begin
            if (accept) begin
                slot_filled[tail] <= 1'b0;
                tail              <= tail + ptr_t'(1);
                fetch_pc          <= fetch_pc + 16'd1;
            end
            if (rsp_fill) begin
                slot_filled[fill] <= 1'b1;
                fill              <= fill + ptr_t'(1);
            end
            if (pop) begin
                slot_filled[head] <= 1'b0;
                head              <= head + ptr_t'(1);
            end
            alloc_cnt <= alloc_cnt + cnt_t'(accept) - cnt_t'(pop);
            pend_cnt  <= pend_cnt + cnt_t'(accept) - cnt_t'(rsp_fill);
            drop_cnt  <= drop_cnt - cnt_t'(rsp_drop);
        end
    end

    // Slot payload needs no reset: it is only visible through the filled bits.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_pc[tail] <= fetch_pc;
        end
        if (rsp_fill && !flush && !rst) begin
            slot_instr[fill] <= imem.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with an in-order variable-latency memory model.
module tb_if_prefetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        halt;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [15:0] if_instr;

    int checks   = 0;
    int failures = 0;

    int unsigned mem_lat = 1;
    int unsigned cyc     = 0;
    logic [15:0] addr_q [$];
    int unsigned due_q  [$];

    always #5 clk = ~clk;

    if_prefetch_unit_if imem ();

    if_prefetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    function automatic logic [15:0] instr_of(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Memory: record accepted requests, answer each mem_lat cycles later, in order.
    always @(posedge clk) begin
        if (rst) begin
            addr_q.delete();
            due_q.delete();
        end else begin
            if (imem.imem_rsp_valid) begin
                void'(addr_q.pop_front());
                void'(due_q.pop_front());
            end
            if (imem.imem_req_valid && imem.imem_req_ready) begin
                addr_q.push_back(imem.imem_req_addr);
                due_q.push_back(cyc + mem_lat);
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (addr_q.size() > 0 && due_q[0] <= cyc) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = instr_of(addr_q[0]);
        end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Leaves the bench at the negedge that opens cycle 0 after reset release.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; flush = 1'b0; halt = 1'b0; redirect_pc = '0;
        imem.imem_req_ready = 1'b1;
        mem_lat = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (imem.imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%0b exp=0", imem.imem_req_valid); end
        checks++;
        if (imem.imem_req_addr !== 16'h0000) begin failures++; $display("FAIL rst_req_addr got=%h exp=0000", imem.imem_req_addr); end
        checks++;
        if ({if_valid, if_pc, if_instr} !== 33'd0) begin failures++; $display("FAIL rst_outputs got=%0b/%h/%h exp=0/0000/0000", if_valid, if_pc, if_instr); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (c == 0) begin
                checks++;
                if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 16'h0000) begin
                    failures++; $display("FAIL rst_first_req got=%0b/%h exp=1/0000", imem.imem_req_valid, imem.imem_req_addr);
                end
            end
            if (c == 2) begin
                checks++;
                if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== instr_of(16'h0000)) begin
                    failures++; $display("FAIL rst_first_entry got=%0b/%h/%h exp=1/0000/%h", if_valid, if_pc, if_instr, instr_of(16'h0000));
                end
            end else begin
                checks++;
                if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_empty c=%0d got=%0b exp=0", c, if_valid); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stream();
        logic [15:0] e;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            #1;
            e = 16'(c);
            checks++;
            if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== e) begin
                failures++; $display("FAIL stream_req c=%0d got=%0b/%h exp=1/%h", c, imem.imem_req_valid, imem.imem_req_addr, e);
            end
            if (c >= 2) begin
                e = 16'(c - 2);
                checks++;
                if (if_valid !== 1'b1 || if_pc !== e || if_instr !== instr_of(e)) begin
                    failures++; $display("FAIL stream_out c=%0d got=%0b/%h/%h exp=1/%h/%h", c, if_valid, if_pc, if_instr, e, instr_of(e));
                end
            end else begin
                checks++;
                if (if_valid !== 1'b0) begin failures++; $display("FAIL stream_empty c=%0d got=%0b exp=0", c, if_valid); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall_full();
        logic [15:0] e;
        do_reset();
        stall = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (imem.imem_req_valid !== (c < 4)) begin
                failures++; $display("FAIL stall_req_valid c=%0d got=%0b exp=%0b", c, imem.imem_req_valid, (c < 4));
            end
            if (c >= 2) begin
                checks++;
                if (if_valid !== 1'b1 || if_pc !== 16'h0000) begin
                    failures++; $display("FAIL stall_head c=%0d got=%0b/%h exp=1/0000", c, if_valid, if_pc);
                end
            end
            @(negedge clk);
        end
        stall = 1'b0;
        for (int c = 10; c < 15; c++) begin
            #1;
            e = 16'(c - 10);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== e || if_instr !== instr_of(e)) begin
                failures++; $display("FAIL stall_drain c=%0d got=%0b/%h/%h exp=1/%h/%h", c, if_valid, if_pc, if_instr, e, instr_of(e));
            end
            if (c == 10) begin
                checks++;
                if (imem.imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_full_block got=%0b exp=0", imem.imem_req_valid); end
            end
            if (c == 11) begin
                checks++;
                if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 16'h0004) begin
                    failures++; $display("FAIL stall_resume got=%0b/%h exp=1/0004", imem.imem_req_valid, imem.imem_req_addr);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush_drop();
        logic [15:0] e;
        do_reset();
        mem_lat = 3;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 16'(c)) begin
                failures++; $display("FAIL fdrop_req c=%0d got=%0b/%h exp=1/%h", c, imem.imem_req_valid, imem.imem_req_addr, 16'(c));
            end
            @(negedge clk);
        end
        imem.imem_req_ready = 1'b0;
        flush = 1'b1; redirect_pc = 16'h0040;
        #1;
        checks++;
        if (imem.imem_req_valid !== 1'b0) begin failures++; $display("FAIL fdrop_flush_req got=%0b exp=0", imem.imem_req_valid); end
        @(negedge clk);
        flush = 1'b0;
        imem.imem_req_ready = 1'b1;
        for (int c = 3; c < 9; c++) begin
            #1;
            if (c == 3) begin
                checks++;
                if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 16'h0040) begin
                    failures++; $display("FAIL fdrop_redirect_req got=%0b/%h exp=1/0040", imem.imem_req_valid, imem.imem_req_addr);
                end
            end
            if (c < 7) begin
                checks++;
                if (if_valid !== 1'b0) begin failures++; $display("FAIL fdrop_stale c=%0d got=%0b/%h exp=0", c, if_valid, if_pc); end
            end else begin
                e = 16'h0040 + 16'(c - 7);
                checks++;
                if (if_valid !== 1'b1 || if_pc !== e || if_instr !== instr_of(e)) begin
                    failures++; $display("FAIL fdrop_out c=%0d got=%0b/%h/%h exp=1/%h/%h", c, if_valid, if_pc, if_instr, e, instr_of(e));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] e;
        do_reset();
        flush = 1'b1; redirect_pc = 16'hFFFE;
        @(negedge clk);
        flush = 1'b0;
        for (int c = 1; c < 7; c++) begin
            #1;
            if (c <= 4) begin
                e = 16'hFFFE + 16'(c - 1);
                checks++;
                if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== e) begin
                    failures++; $display("FAIL wrap_req c=%0d got=%0b/%h exp=1/%h", c, imem.imem_req_valid, imem.imem_req_addr, e);
                end
            end
            if (c >= 3) begin
                e = 16'hFFFE + 16'(c - 3);
                checks++;
                if (if_valid !== 1'b1 || if_pc !== e || if_instr !== instr_of(e)) begin
                    failures++; $display("FAIL wrap_out c=%0d got=%0b/%h/%h exp=1/%h/%h", c, if_valid, if_pc, if_instr, e, instr_of(e));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        logic [15:0] e;
        do_reset();
        mem_lat = 2;
        repeat (2) @(negedge clk);
        halt = 1'b1;
        for (int c = 2; c < 6; c++) begin
            #1;
            checks++;
            if (imem.imem_req_valid !== 1'b0) begin failures++; $display("FAIL halt_req c=%0d got=%0b exp=0", c, imem.imem_req_valid); end
            if (c == 3 || c == 4) begin
                e = 16'(c - 3);
                checks++;
                if (if_valid !== 1'b1 || if_pc !== e || if_instr !== instr_of(e)) begin
                    failures++; $display("FAIL halt_out c=%0d got=%0b/%h/%h exp=1/%h/%h", c, if_valid, if_pc, if_instr, e, instr_of(e));
                end
            end else begin
                checks++;
                if (if_valid !== 1'b0) begin failures++; $display("FAIL halt_empty c=%0d got=%0b exp=0", c, if_valid); end
            end
            @(negedge clk);
        end
        flush = 1'b1; redirect_pc = 16'h0010;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (imem.imem_req_valid !== 1'b0) begin failures++; $display("FAIL halt_after_flush got=%0b exp=0", imem.imem_req_valid); end
        @(negedge clk);
        halt = 1'b0;
        #1;
        checks++;
        if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 16'h0010) begin
            failures++; $display("FAIL halt_resume got=%0b/%h exp=1/0010", imem.imem_req_valid, imem.imem_req_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_flush_pop_rsp();
        do_reset();
        repeat (2) @(negedge clk);
        imem.imem_req_ready = 1'b0;
        flush = 1'b1; redirect_pc = 16'h0020;
        #1;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0000) begin
            failures++; $display("FAIL fpr_pre got=%0b/%h exp=1/0000", if_valid, if_pc);
        end
        @(negedge clk);
        flush = 1'b0;
        imem.imem_req_ready = 1'b1;
        for (int c = 3; c < 7; c++) begin
            #1;
            if (c == 3) begin
                checks++;
                if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 16'h0020) begin
                    failures++; $display("FAIL fpr_req got=%0b/%h exp=1/0020", imem.imem_req_valid, imem.imem_req_addr);
                end
            end
            if (c < 5) begin
                checks++;
                if (if_valid !== 1'b0) begin failures++; $display("FAIL fpr_empty c=%0d got=%0b/%h exp=0", c, if_valid, if_pc); end
            end else begin
                checks++;
                if (if_valid !== 1'b1 || if_pc !== 16'h001B + 16'(c) || if_instr !== instr_of(16'h001B + 16'(c))) begin
                    failures++; $display("FAIL fpr_out c=%0d got=%0b/%h/%h exp=1/%h/%h", c, if_valid, if_pc, if_instr,
                                         16'h001B + 16'(c), instr_of(16'h001B + 16'(c)));
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; halt = 1'b0; redirect_pc = '0;
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
        test_reset();
        test_stream();
        test_stall_full();
        test_flush_drop();
        test_wrap();
        test_halt();
        test_flush_pop_rsp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
